// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed seven-segment scanner with a frame-synchronous double buffer.
// Define SEG_SCAN_LZ_BLANK_EN to blank leading zero digits.
module seg_scan_driver #(
  parameter int CLOCK_FREQ = 50000000,
  parameter int SCAN_FREQ = 1000,
  parameter int NUM_DIGITS = 8,
  parameter int BLANK_CYCLES = 16,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  output logic                    frame_done,
  output logic [7:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_sel
);
  localparam int DWELL = CLOCK_FREQ / SCAN_FREQ;
  localparam int CW = $clog2(DWELL + 1);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES > 0 ? BLANK_CYCLES - 1 : 0);
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);
  localparam logic [7:0] SEG_OFF = SEG_ACTIVE_LOW != 0 ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW != 0 ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};
  localparam logic [NUM_DIGITS-1:0] ONE = 1;
  typedef enum logic {BLANK, SHOW} state_t;
  localparam state_t SLOT_START = BLANK_CYCLES == 0 ? SHOW : BLANK;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] pend_bcd_q, pend_bcd_d, act_bcd_q, act_bcd_d;
  logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
  logic pend_flag_q, pend_flag_d;
  logic [7:0] seg_q, seg_d;
  logic [NUM_DIGITS-1:0] dig_q, dig_d;
  logic done_q, done_d;
  logic [NUM_DIGITS-1:0] lz;
  logic wrap, show;
  logic [3:0] code;
  logic [7:0] lit;

  function automatic logic [6:0] decode(input logic [3:0] c);
    case (c)
      4'd0: decode = 7'b0111111;
      4'd1: decode = 7'b0000110;
      4'd2: decode = 7'b1011011;
      4'd3: decode = 7'b1001111;
      4'd4: decode = 7'b1100110;
      4'd5: decode = 7'b1101101;
      4'd6: decode = 7'b1111101;
      4'd7: decode = 7'b0000111;
      4'd8: decode = 7'b1111111;
      4'd9: decode = 7'b1101111;
      4'hA: decode = 7'b1000000;
      default: decode = 7'b0000000;
    endcase
  endfunction

`ifdef SEG_SCAN_LZ_BLANK_EN
  logic run;
  // Blanking run starts at the leftmost digit and stops at the first significant one.
  always_comb begin
    lz = '0;
    run = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      run = run & (act_bcd_q[4*i +: 4] == 4'd0) & ~act_dp_q[i];
      lz[i] = run;
    end
  end
`else
  assign lz = '0;
`endif

  always_comb begin
    show = state_q == SHOW;
    wrap = show && cnt_q == DWELL_LAST && idx_q == IDX_LAST;
    state_d = state_q;
    cnt_d = cnt_q + 1'b1;
    idx_d = idx_q;
    if (!show) begin
      if (cnt_q == BLANK_LAST) state_d = SHOW;
    end else if (cnt_q == DWELL_LAST) begin
      cnt_d = '0;
      idx_d = idx_q == IDX_LAST ? '0 : idx_q + 1'b1;
      state_d = SLOT_START;
    end
    // A load on the wrap edge keeps the flag set so the new data commits next frame.
    pend_bcd_d = load ? bcd_in : pend_bcd_q;
    pend_dp_d = load ? dp_in : pend_dp_q;
    pend_flag_d = load | (pend_flag_q & ~wrap);
    act_bcd_d = wrap && pend_flag_q ? pend_bcd_q : act_bcd_q;
    act_dp_d = wrap && pend_flag_q ? pend_dp_q : act_dp_q;
    code = act_bcd_q[{idx_q, 2'b00} +: 4];
    lit = lz[idx_q] ? 8'h00 : {act_dp_q[idx_q], decode(code)};
    seg_d = show ? lit ^ SEG_OFF : SEG_OFF;
    dig_d = show ? (ONE << idx_q) ^ DIG_OFF : DIG_OFF;
    done_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= SLOT_START;
      cnt_q <= '0;
      idx_q <= '0;
      pend_bcd_q <= '0;
      pend_dp_q <= '0;
      pend_flag_q <= 1'b0;
      act_bcd_q <= '0;
      act_dp_q <= '0;
      seg_q <= SEG_OFF;
      dig_q <= DIG_OFF;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      pend_bcd_q <= pend_bcd_d;
      pend_dp_q <= pend_dp_d;
      pend_flag_q <= pend_flag_d;
      act_bcd_q <= act_bcd_d;
      act_dp_q <= act_dp_d;
      seg_q <= seg_d;
      dig_q <= dig_d;
      done_q <= done_d;
    end
  end

  assign seg = seg_q;
  assign dig_sel = dig_q;
  assign frame_done = done_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// tb_seg_scan_driver: scoreboard bench for seg_scan_driver with a 4-digit, 10-cycle-dwell, 2-cycle-blank setup.
module tb_seg_scan_driver;
`ifdef SEG_SCAN_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1, load = 1'b0, frame_done;
  logic [15:0] bcd_in = '0;
  logic [3:0] dp_in = '0, dig_sel;
  logic [7:0] seg;
  int n_cmp = 0, n_bad = 0, cyc = 0;
  logic [15:0] act_bcd = '0, pend_bcd = '0;
  logic [3:0] act_dp = '0, pend_dp = '0;
  logic pflag = 1'b0;
  logic [12:0] sb_q[$];
  logic [6:0] tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h40, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00};

  seg_scan_driver #(.CLOCK_FREQ(100), .SCAN_FREQ(10), .NUM_DIGITS(4), .BLANK_CYCLES(2),
                    .SEG_ACTIVE_LOW(0), .DIG_ACTIVE_LOW(1)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .dp_in(dp_in), .load(load),
    .frame_done(frame_done), .seg(seg), .dig_sel(dig_sel));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [12:0] expect_out(input int c);
    int d;
    logic [3:0] code;
    logic blank;
    logic [7:0] s;
    d = (c / 10) % 4;
    code = act_bcd[d*4 +: 4];
    blank = LZ && d > 0;
    for (int j = d; j < 4; j++)
      if (act_bcd[j*4 +: 4] != 4'd0 || act_dp[j]) blank = 1'b0;
    s = blank ? 8'h00 : {act_dp[d], tab[code]};
    if (c % 10 < 2) return {1'b0, 4'hF, 8'h00};
    return {c % 40 == 39, ~(4'b0001 << d), s};
  endfunction

  task automatic step(input logic ld, input logic [15:0] b, input logic [3:0] d);
    logic [12:0] exp_v;
    string tag;
    @(negedge clk);
    load = ld;
    bcd_in = b;
    dp_in = d;
    tag = rst ? "rst_hold" : $sformatf("cyc%0d", cyc);
    sb_q.push_back(rst ? {1'b0, 4'hF, 8'h00} : expect_out(cyc));
    if (!rst) begin
      if (cyc % 40 == 39 && pflag) begin
        act_bcd = pend_bcd;
        act_dp = pend_dp;
        pflag = 1'b0;
      end
      if (ld) begin
        pend_bcd = b;
        pend_dp = d;
        pflag = 1'b1;
      end
      cyc++;
    end
    @(posedge clk);
    #1;
    exp_v = sb_q.pop_front();
    chk(tag, {frame_done, dig_sel, seg}, exp_v);
  endtask

  task automatic run_to(input int c);
    while (cyc <= c) step(1'b0, bcd_in, dp_in);
  endtask

  initial begin
    repeat (5) step(1'b0, 16'h0, 4'h0);
    chk("rst_seg", seg, 8'h00);
    chk("rst_dig", dig_sel, 4'hF);
    rst = 1'b0;
    run_to(1);
    chk("c1_dig", dig_sel, 4'hF);
    run_to(2);
    chk("c2_dig", dig_sel, 4'hE);
    chk("c2_seg", seg, 8'h3F);
    run_to(10);
    chk("c10_dig", dig_sel, 4'hF);
    run_to(14);
    step(1'b1, 16'h1234, 4'b0100);
    run_to(22);
    chk("f1_d2_old", seg, LZ ? 8'h00 : 8'h3F);
    run_to(38);
    chk("c38_done", frame_done, 1'b0);
    step(1'b1, 16'h5678, 4'b0000);
    chk("c39_done", frame_done, 1'b1);
    run_to(42); chk("f2_d0", seg, 8'h66);
    run_to(52); chk("f2_d1", seg, 8'h4F);
    run_to(62); chk("f2_d2", seg, 8'hDB);
    run_to(72); chk("f2_d3", seg, 8'h06);
    run_to(79); chk("c79_done", frame_done, 1'b1);
    run_to(82); chk("f3_d0", seg, 8'h7F);
    step(1'b1, 16'h0000, 4'h0);
    run_to(84);
    step(1'b1, 16'hFA09, 4'h0);
    run_to(122); chk("f4_d0", seg, 8'h6F);
    run_to(142); chk("code_a", seg, 8'h40);
    run_to(152); chk("code_f", seg, 8'h00);
    chk("code_f_dig", dig_sel, 4'h7);
    step(1'b1, 16'h1111, 4'hF);
    run_to(155);
    rst = 1'b1;
    #1;
    chk("async_seg", seg, 8'h00);
    chk("async_dig", dig_sel, 4'hF);
    chk("async_done", frame_done, 1'b0);
    cyc = 0;
    act_bcd = '0; act_dp = '0; pend_bcd = '0; pend_dp = '0; pflag = 1'b0;
    repeat (2) step(1'b0, 16'h0, 4'h0);
    rst = 1'b0;
    run_to(2);
    chk("restart_dig", dig_sel, 4'hE);
    run_to(42);
    chk("pend_lost", seg, 8'h3F);
    run_to(49);
    step(1'b1, 16'h0070, 4'h0);
    run_to(82); chk("lz1_d0", seg, 8'h3F);
    run_to(92); chk("lz1_d1", seg, 8'h07);
    run_to(102); chk("lz1_d2", seg, LZ ? 8'h00 : 8'h3F);
    chk("lz1_d2_dig", dig_sel, 4'hB);
    run_to(112); chk("lz1_d3", seg, LZ ? 8'h00 : 8'h3F);
    run_to(114);
    step(1'b1, 16'h0000, 4'h0);
    run_to(122); chk("lz2_d0", seg, 8'h3F);
    run_to(132); chk("lz2_d1", seg, LZ ? 8'h00 : 8'h3F);
    run_to(139);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
